// File: rtl/ps2_scancode_decoder_if.sv
// Byte input, event output and status bundle for ps2_scancode_decoder.
// The master side is the byte source and event consumer; the slave side is the decoder.
interface ps2_scancode_decoder_if #(
    parameter int unsigned DEPTH = 8
);
    logic                       in_valid;
    logic [7:0]                 in_byte;
    logic                       ev_valid;
    logic [9:0]                 ev_data;
    logic                       ev_ready;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                       overflow;
    logic                       clear_overflow;
    logic                       timeout_err;
    logic                       proto_err;
    logic [2:0]                 state;

    modport master (
        output in_valid, in_byte, ev_ready, clear_overflow,
        input  ev_valid, ev_data, fifo_count, overflow, timeout_err, proto_err, state
    );

    modport slave (
        input  in_valid, in_byte, ev_ready, clear_overflow,
        output ev_valid, ev_data, fifo_count, overflow, timeout_err, proto_err, state
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Scan-code set 2 parser feeding a first-word-fall-through {ext, brk, code} event FIFO.
// Define PS2_REPEAT_FILTER_EN to drop typematic repeats of the most recent make.
module ps2_scancode_decoder #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input logic                   clk,
    input logic                   reset_n,
    ps2_scancode_decoder_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SW = $clog2(PAUSE_SKIP + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StExt    = 3'd1,
        StBrk    = 3'd2,
        StExtBrk = 3'd3,
        StPause  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [SW-1:0]   skip_q, skip_d;
    logic            timeout_err_q, proto_err_q;
    logic            push, proto, tmo, ev_push;
    logic [9:0]      push_data;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        skip_d    = skip_q;
        push      = 1'b0;
        push_data = '0;
        proto     = 1'b0;
        tmo       = 1'b0;
        if (bus.in_valid) begin
            timer_d = '0;
            unique case (state_q)
                StIdle: begin
                    case (bus.in_byte)
                        8'hE0: state_d = StExt;
                        8'hF0: state_d = StBrk;
                        8'hE1: begin
                            state_d = StPause;
                            skip_d  = SW'(PAUSE_SKIP);
                        end
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin end
                        default: begin
                            push      = 1'b1;
                            push_data = {2'b00, bus.in_byte};
                        end
                    endcase
                end
                StExt: begin
                    state_d = StIdle;
                    if (bus.in_byte == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (bus.in_byte == 8'hE0 || bus.in_byte == 8'hE1) begin
                        proto = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = {2'b10, bus.in_byte};
                    end
                end
                StBrk, StExtBrk: begin
                    state_d = StIdle;
                    if (bus.in_byte inside {8'hE0, 8'hE1, 8'hF0}) begin
                        proto = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = {(state_q == StExtBrk), 1'b1, bus.in_byte};
                    end
                end
                StPause: begin
                    // Pause bytes carry no information; only their count matters.
                    if (skip_q <= SW'(1)) begin
                        state_d   = StIdle;
                        push      = 1'b1;
                        push_data = {2'b10, 8'h77};
                    end else begin
                        skip_d = skip_q - SW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo     = 1'b1;
                state_d = StIdle;
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            skip_q        <= '0;
            timeout_err_q <= 1'b0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            skip_q        <= skip_d;
            timeout_err_q <= tmo;
            proto_err_q   <= proto;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic       lm_valid_q, lm_valid_d;
    logic [8:0] lm_key_q, lm_key_d;
    logic       repeat_hit;

    always_comb begin
        lm_valid_d = lm_valid_q;
        lm_key_d   = lm_key_q;
        repeat_hit = push && !push_data[8] && lm_valid_q &&
                     (lm_key_q == {push_data[9], push_data[7:0]});
        if (tmo) begin
            lm_valid_d = 1'b0;
        end else if (push && !push_data[8]) begin
            lm_valid_d = 1'b1;
            lm_key_d   = {push_data[9], push_data[7:0]};
        end else if (push && (lm_key_q == {push_data[9], push_data[7:0]})) begin
            lm_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lm_valid_q <= 1'b0;
            lm_key_q   <= '0;
        end else begin
            lm_valid_q <= lm_valid_d;
            lm_key_q   <= lm_key_d;
        end
    end

    assign ev_push = push && !repeat_hit;
`else
    assign ev_push = push;
`endif

    logic [9:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          full, pop, wr, drop;

    assign full = (count_q == CW'(DEPTH));
    assign pop  = bus.ev_ready && (count_q != '0);
    assign wr   = ev_push && (!full || pop);
    assign drop = ev_push && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (wr && !pop)      count_q <= count_q + CW'(1);
            else if (!wr && pop) count_q <= count_q - CW'(1);
            // A drop in the same cycle outranks the clear.
            if (drop)                    overflow_q <= 1'b1;
            else if (bus.clear_overflow) overflow_q <= 1'b0;
        end
    end

    assign bus.ev_valid    = (count_q != '0);
    assign bus.ev_data     = mem_q[rd_ptr_q];
    assign bus.fifo_count  = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.proto_err   = proto_err_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised scoreboard bench for ps2_scancode_decoder against a sequence-level reference model.
// Honours PS2_REPEAT_FILTER_EN in the model the same way the design does.
module tb_ps2_scancode_decoder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 4000;
    localparam int unsigned SKIP  = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ps2_scancode_decoder_if #(.DEPTH(DEPTH)) bus ();

    ps2_scancode_decoder #(
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .PAUSE_SKIP(SKIP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass = 0;

    // Reference model: expected FIFO contents, bytes of the open sequence, status.
    logic [9:0] exp_q[$];
    logic [7:0] seq[$];
    int         skip_left = 0;
    int         idle_cnt = 0;
    bit         ovf_m = 0, tmo_m = 0, proto_m = 0;
    bit         lm_valid = 0;
    logic [8:0] lm_key = '0;
    logic [9:0] mon_exp;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic int model_state();
        if (seq.size() == 0) return 0;
        if (seq[0] == 8'hE1) return 4;
        if (seq[0] == 8'hE0) return (seq.size() == 2) ? 3 : 1;
        return 2;
    endfunction

    function automatic bit is_ignored(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    task automatic step(input bit v, input logic [7:0] b, input bit rdy, input bit clr);
        bit pop, ev_got, drop, ext, brk;
        logic [9:0] ev;
        bus.in_valid       = v;
        bus.in_byte        = b;
        bus.ev_ready       = rdy;
        bus.clear_overflow = clr;
        pop = rdy && (exp_q.size() > 0);
        tmo_m = 0; proto_m = 0; ev_got = 0; drop = 0; ev = '0;
        if (v) begin
            idle_cnt = 0;
            if (seq.size() == 0) begin
                if (b == 8'hE0 || b == 8'hF0) seq.push_back(b);
                else if (b == 8'hE1) begin
                    seq.push_back(b);
                    skip_left = SKIP;
                end else if (!is_ignored(b)) begin
                    ev = {2'b00, b};
                    ev_got = 1;
                end
            end else if (seq[0] == 8'hE1) begin
                skip_left--;
                if (skip_left == 0) begin
                    ev = {2'b10, 8'h77};
                    ev_got = 1;
                    seq.delete();
                end
            end else begin
                ext = (seq[0] == 8'hE0);
                brk = (seq[seq.size()-1] == 8'hF0);
                if (b == 8'hF0 && ext && !brk) seq.push_back(b);
                else if (b inside {8'hE0, 8'hE1, 8'hF0}) begin
                    proto_m = 1;
                    seq.delete();
                end else begin
                    ev = {ext, brk, b};
                    ev_got = 1;
                    seq.delete();
                end
            end
        end else if (seq.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                tmo_m = 1;
                seq.delete();
                idle_cnt = 0;
                lm_valid = 0;
            end
        end
`ifdef PS2_REPEAT_FILTER_EN
        if (ev_got) begin
            if (!ev[8]) begin
                if (lm_valid && lm_key == {ev[9], ev[7:0]}) ev_got = 0;
                else begin
                    lm_valid = 1;
                    lm_key = {ev[9], ev[7:0]};
                end
            end else if (lm_valid && lm_key == {ev[9], ev[7:0]}) begin
                lm_valid = 0;
            end
        end
`endif
        if (ev_got) begin
            if (exp_q.size() >= DEPTH && !pop) drop = 1;
            else exp_q.push_back(ev);
        end
        if (drop) ovf_m = 1;
        else if (clr) ovf_m = 0;
        @(posedge clk);
        #1;
        check("fifo_count", int'(bus.fifo_count), exp_q.size());
        check("ev_valid", int'(bus.ev_valid), int'(exp_q.size() > 0));
        check("overflow", int'(bus.overflow), int'(ovf_m));
        check("timeout_err", int'(bus.timeout_err), int'(tmo_m));
        check("proto_err", int'(bus.proto_err), int'(proto_m));
        check("state", int'(bus.state), model_state());
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 8'h00, rdy, 0);
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        step(1, b, rdy, 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        bus.in_valid = 0;
        bus.in_byte = '0;
        bus.ev_ready = 0;
        bus.clear_overflow = 0;
        exp_q.delete();
        seq.delete();
        idle_cnt = 0;
        skip_left = 0;
        ovf_m = 0;
        lm_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        check("rst ev_valid", int'(bus.ev_valid), 0);
        check("rst ev_data", int'(bus.ev_data), 0);
        check("rst fifo_count", int'(bus.fifo_count), 0);
        check("rst overflow", int'(bus.overflow), 0);
        check("rst timeout_err", int'(bus.timeout_err), 0);
        check("rst proto_err", int'(bus.proto_err), 0);
        check("rst state", int'(bus.state), 0);
    endtask

    // Monitor: every accepted pop is checked against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n && bus.ev_valid && bus.ev_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ev_data: got unexpected event 0x%0h, required none at %0t",
                         bus.ev_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("ev_data", int'(bus.ev_data), int'(mon_exp));
            end
        end
    end

    initial begin
        logic [7:0] rb;
        int r;
        do_reset();

        // Plain make/break with gaps, consumer stalled, then drained in order.
        send(8'h1C, 0); idle(9, 0);
        send(8'hF0, 0); idle(9, 0);
        send(8'h1C, 0); idle(3, 0);
        idle(4, 1);

        // Extended make/break, then the Pause sequence.
        send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1); send(8'hE1, 1);
        send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1); send(8'h77, 1);
        idle(3, 1);

        // Timeout: expires after a full idle window, but a byte on the expiry cycle wins.
        send(8'hF0, 1); idle(TMO, 1); idle(2, 1);
        send(8'hF0, 1); idle(TMO - 1, 1); send(8'h2B, 1); idle(3, 1);

        // Overflow with the consumer stalled, clear, then full push-with-pop.
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 0);
        step(0, 8'h00, 0, 1);
        step(1, 8'h2A, 1, 0);
        idle(12, 1);

        // Protocol error and typematic repeats.
        send(8'hE0, 1); send(8'hE0, 1); idle(2, 1);
        send(8'h1C, 1); send(8'h1C, 1); send(8'h1C, 1);
        send(8'hF0, 1); send(8'h1C, 1); send(8'h1C, 1);
        idle(8, 1);

        // Reset mid-sequence and with a non-empty FIFO.
        send(8'h1C, 0); send(8'hE0, 0);
        do_reset();

        // Randomised byte stream, gaps, back-pressure and clears.
        for (int n = 0; n < 2500; n++) begin
            for (int g = int'($urandom_range(0, 3)); g > 0; g--)
                step(0, 8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            r = int'($urandom_range(0, 19));
            if (r < 3) rb = 8'hE0;
            else if (r < 6) rb = 8'hF0;
            else if (r == 6) rb = 8'hE1;
            else if (r == 7) rb = 8'hAA;
            else if (r < 12) rb = 8'h10 + 8'($urandom_range(0, 3));
            else rb = 8'($urandom);
            step(1, rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        idle(SKIP + 20, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
